// File: rtl/nap_timer_pkg.sv
// ============================================================================
// Module   : nap_timer_pkg
// Brief    : Shared states, BCD limits and width helpers for the nap timer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nap_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] one_min;
      logic [3:0] ten_sec;
      logic [3:0] one_sec;
   } nap_time_t;

   localparam logic [3:0] C_BCD_MAX_ONES = 4'd9;
   localparam logic [3:0] C_BCD_MAX_TENS = 4'd5;

   // Ceiling log2 with a floor of one bit, so tiny parameters still get a register.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(value)) w = w + 1;
      return w;
   endfunction

   function automatic int unsigned alarm_cnt_width(input int unsigned secs);
      return clog2(secs);
   endfunction

endpackage

`default_nettype wire

// File: rtl/nap_tick_gen.sv
// ============================================================================
// Module   : nap_tick_gen
// Brief    : Prescaler producing a one-cycle tick every CLK_DIV clocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nap_tick_gen
   import nap_timer_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50_000_000,
   parameter int unsigned CNT_W   = clog2(CLK_DIV)
) (
   input  logic clock,
   input  logic reset,
   input  logic clear_i,
   input  logic hold_i,
   output logic tick_o
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_last;

   assign at_last = (cnt_q == C_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (!hold_i) begin
         cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = at_last && !clear_i && !hold_i;

endmodule

`default_nettype wire

// File: rtl/nap_countdown_timer.sv
// ============================================================================
// Module   : nap_countdown_timer
// Brief    : BCD nap countdown (M:SS) with alarm phase; optional pause
//            support enabled by defining NAP_PAUSE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nap_countdown_timer
   import nap_timer_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 50_000_000,
   parameter int unsigned ALARM_SECS = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] preset_one_sec,
   input  logic [3:0] preset_ten_sec,
   input  logic [3:0] preset_one_min,
   input  logic       start,
   input  logic       stop,
   input  logic       ack,
   input  logic       pause,
   output logic [3:0] rem_one_sec,
   output logic [3:0] rem_ten_sec,
   output logic [3:0] rem_one_min,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   localparam int unsigned       C_ALM_W    = alarm_cnt_width(ALARM_SECS);
   localparam logic [C_ALM_W-1:0] C_ALM_LAST = C_ALM_W'(ALARM_SECS - 1);
   localparam nap_time_t         C_TIME_001 = 12'h001;

   state_t             state_q, state_d;
   nap_time_t          preset_q, preset_d;
   nap_time_t          count_q, count_d;
   logic [C_ALM_W-1:0] alm_cnt_q, alm_cnt_d;
   logic               start_q;
   logic               was_alarm_q;
   logic               done_q;

   logic               start_rise;
   logic               capture;
   nap_time_t          clamped;
   logic               tick;
   logic               presc_clear;
   logic               presc_hold;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   function automatic nap_time_t bcd_dec(input nap_time_t t);
      nap_time_t r;
      r = t;
      if (t.one_sec != 4'd0) begin
         r.one_sec = t.one_sec - 4'd1;
      end else begin
         r.one_sec = C_BCD_MAX_ONES;
         if (t.ten_sec != 4'd0) begin
            r.ten_sec = t.ten_sec - 4'd1;
         end else begin
            r.ten_sec = C_BCD_MAX_TENS;
            r.one_min = t.one_min - 4'd1;
         end
      end
      return r;
   endfunction

   assign start_rise      = start && !start_q;
   assign capture         = |{preset_one_min, preset_ten_sec, preset_one_sec};
   assign clamped.one_min = clamp_digit(preset_one_min, C_BCD_MAX_ONES);
   assign clamped.ten_sec = clamp_digit(preset_ten_sec, C_BCD_MAX_TENS);
   assign clamped.one_sec = clamp_digit(preset_one_sec, C_BCD_MAX_ONES);

   // Prescaler sits at zero in IDLE so the first tick lands CLK_DIV cycles into RUN.
   assign presc_clear = (state_q == ST_IDLE);

`ifdef NAP_PAUSE_EN
   assign presc_hold = pause && ((state_q == ST_RUN) || (state_q == ST_PAUSE));
`else
   logic pause_unused;
   assign pause_unused = pause;
   assign presc_hold   = 1'b0;
`endif

   nap_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick_gen (
      .clock   (clock),
      .reset   (reset),
      .clear_i (presc_clear),
      .hold_i  (presc_hold),
      .tick_o  (tick)
   );

   always_comb begin
      state_d   = state_q;
      preset_d  = preset_q;
      count_d   = count_q;
      alm_cnt_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (capture) preset_d = clamped;
            if (!stop && start_rise && (preset_q != '0)) begin
               state_d = ST_RUN;
               count_d = preset_q;
            end
         end
         ST_RUN, ST_PAUSE: begin
            if (stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end
`ifdef NAP_PAUSE_EN
            else if (pause) begin
               state_d = ST_PAUSE;
            end
`endif
            else begin
               state_d = ST_RUN;
               if (tick) begin
                  if (count_q == C_TIME_001) begin
                     state_d = ST_ALARM;
                     count_d = '0;
                  end else begin
                     count_d = bcd_dec(count_q);
                  end
               end
            end
         end
         ST_ALARM: begin
            count_d   = '0;
            alm_cnt_d = alm_cnt_q;
            if (stop || ack) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (alm_cnt_q == C_ALM_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  alm_cnt_d = alm_cnt_q + C_ALM_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         preset_q    <= '0;
         count_q     <= '0;
         alm_cnt_q   <= '0;
         start_q     <= 1'b0;
         was_alarm_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         preset_q    <= preset_d;
         count_q     <= count_d;
         alm_cnt_q   <= alm_cnt_d;
         start_q     <= start;
         was_alarm_q <= (state_q == ST_ALARM);
         done_q      <= (state_q == ST_ALARM) && !was_alarm_q;
      end
   end

   always_comb begin
      {rem_one_min, rem_ten_sec, rem_one_sec} = count_q;
      case (state_q)
         ST_IDLE:  {rem_one_min, rem_ten_sec, rem_one_sec} = preset_q;
         ST_ALARM: {rem_one_min, rem_ten_sec, rem_one_sec} = 12'h000;
         default:  {rem_one_min, rem_ten_sec, rem_one_sec} = count_q;
      endcase
   end

   assign running = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign alarm   = (state_q == ST_ALARM);
   assign done    = done_q;

endmodule

`default_nettype wire
